// File: rtl/mux_nx1_arb.sv
// NUM_CH-to-1 registered stream mux with a built-in round-robin or fixed-priority arbiter.
// A one-entry output stage drains and reloads on the same edge for full throughput.
module mux_nx1_arb #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned MODE   = 0,
  localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enb,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;

  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_found;
  logic [NUM_CH-1:0] grant;
  logic [DATA_W-1:0] gnt_data;
  logic              load;

  // First valid channel at or after the search start, wrapping at NUM_CH-1.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (MODE == 0) begin
        idx = 32'(ptr_q) + k;
        if (idx >= NUM_CH) begin
          idx = idx - NUM_CH;
        end
      end else begin
        idx = k;
      end
      if (!gnt_found && in_valid[idx[CH_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    grant    = '0;
    gnt_data = '0;
    if (gnt_found) begin
      grant[gnt_idx] = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == gnt_idx) begin
        gnt_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // rst_n is folded in so no channel sees a handshake while reset is held.
  assign load     = rst_n & enb & gnt_found & (~valid_q | out_ready);
  assign in_ready = load ? grant : '0;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (load) begin
      data_d  = gnt_data;
      ch_d    = gnt_idx;
      valid_d = 1'b1;
      if (MODE == 0) begin
        ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Drives three arbiter variants (4ch RR, 4ch fixed, 3ch RR) from shared stimulus and checks
// each against a per-cycle stream model plus hand-computed literal expectations.
module tb_mux_nx1_arb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enb, out_ready;
  logic [3:0]  in_valid;
  logic [31:0] in_data;

  logic [3:0]  ir0, ir1;
  logic [2:0]  ir2;
  logic [7:0]  od0, od1, od2;
  logic        ov0, ov1, ov2;
  logic [1:0]  och0, och1, och2;

  logic [3:0]  ir_a  [3];
  logic [7:0]  od_a  [3];
  logic        ov_a  [3];
  logic [1:0]  och_a [3];

  always_comb begin
    ir_a[0] = ir0;  ir_a[1] = ir1;  ir_a[2] = {1'b0, ir2};
    od_a[0] = od0;  od_a[1] = od1;  od_a[2] = od2;
    ov_a[0] = ov0;  ov_a[1] = ov1;  ov_a[2] = ov2;
    och_a[0] = och0; och_a[1] = och1; och_a[2] = och2;
  end

  mux_nx1_arb #(.DATA_W(8), .NUM_CH(4), .MODE(0)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .enb(enb), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .out_ch(och0)
  );

  mux_nx1_arb #(.DATA_W(8), .NUM_CH(4), .MODE(1)) u_fx4 (
    .clk(clk), .rst_n(rst_n), .enb(enb), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_ch(och1)
  );

  mux_nx1_arb #(.DATA_W(8), .NUM_CH(3), .MODE(0)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .enb(enb), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]),
    .in_ready(ir2), .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .out_ch(och2)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stream model: one holding slot per instance, winner picked by plain modulo search.
  int         nch    [3] = '{4, 4, 3};
  int         mode   [3] = '{0, 1, 0};
  int         m_ptr  [3] = '{0, 0, 0};
  int         m_ch   [3] = '{0, 0, 0};
  logic       m_v    [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] m_d    [3] = '{8'h00, 8'h00, 8'h00};

  function automatic int pick(int j);
    for (int k = 0; k < nch[j]; k++) begin
      int c;
      c = (mode[j] == 1) ? k : (m_ptr[j] + k) % nch[j];
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < 3; j++) begin
        int         c;
        logic       ld;
        logic [3:0] exp_ir;
        c      = pick(j);
        ld     = rst_n && enb && (c >= 0) && (!m_v[j] || out_ready);
        exp_ir = ld ? (4'b0001 << c) : 4'b0000;
        chk($sformatf("u%0d in_ready", j), 32'(ir_a[j]), 32'(exp_ir));
        chk($sformatf("u%0d out_valid", j), 32'(ov_a[j]), 32'(m_v[j]));
        chk($sformatf("u%0d out_data", j), 32'(od_a[j]), 32'(m_d[j]));
        chk($sformatf("u%0d out_ch", j), 32'(och_a[j]), 32'(m_ch[j]));
        if (!rst_n) begin
          m_v[j] = 1'b0; m_d[j] = 8'h00; m_ch[j] = 0; m_ptr[j] = 0;
        end else if (ld) begin
          m_d[j]  = in_data[c*8 +: 8];
          m_ch[j] = c;
          m_v[j]  = 1'b1;
          if (mode[j] == 0) m_ptr[j] = (c + 1) % nch[j];
        end else if (out_ready) begin
          m_v[j] = 1'b0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // {enb, out_ready, in_valid}
  logic [5:0] vec [10] = '{6'b10_1010, 6'b10_0000, 6'b11_0000, 6'b01_1111, 6'b11_1000,
                           6'b11_1001, 6'b00_0110, 6'b10_0110, 6'b11_0110, 6'b11_0011};

  initial begin
    int exp_seq [4] = '{2, 0, 2, 0};
    rst_n     = 1'b0;
    enb       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    in_data   = 32'hA3A2A1A0;
    step(1);
    chk_en = 1'b1;
    step(1);

    // Reset with every channel requesting.
    chk("t1 in_ready rr", 32'(ir0), 32'h0);
    chk("t1 in_ready fx", 32'(ir1), 32'h0);
    chk("t1 out_valid", 32'(ov0), 32'h0);
    chk("t1 out_data", 32'(od0), 32'h00);
    chk("t1 out_ch", 32'(och0), 32'h0);

    // Round-robin rotation and fixed-priority starvation of ch1..3.
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t2 out_ch", 32'(och0), 32'(i % 4));
      chk("t2 out_data", 32'(od0), 32'(8'hA0 + i % 4));
      chk("t2 out_valid", 32'(ov0), 32'h1);
      chk("t3 in_ready", 32'(ir1), 32'h1);
      chk("t3 out_data", 32'(od1), 32'hA0);
    end

    // Back-pressure: 5C held, then the next word loads on the releasing edge.
    in_valid = 4'b0001;
    in_data  = 32'hA3A2A15C;
    step(1);
    chk("t4 load 5C", 32'(od0), 32'h5C);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 32'hA3A2A1A0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t4 held data", 32'(od0), 32'h5C);
      chk("t4 held valid", 32'(ov0), 32'h1);
      chk("t4 held in_ready", 32'(ir0), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("t4 release in_ready", 32'(ir0), 32'h2);
    step(1);
    chk("t4 next data", 32'(od0), 32'hA1);
    chk("t4 next ch", 32'(och0), 32'h1);

    // Enable low: drain only, pointer frozen at 2.
    enb = 1'b0;
    #1;
    chk("t5 in_ready enb0", 32'(ir0), 32'h0);
    step(1);
    chk("t5 drained", 32'(ov0), 32'h0);
    step(1);
    chk("t5 idle valid", 32'(ov0), 32'h0);
    chk("t5 idle in_ready", 32'(ir0), 32'h0);
    enb = 1'b1;
    #1;
    chk("t5 resume in_ready", 32'(ir0), 32'h4);
    step(1);
    chk("t5 resume ch", 32'(och0), 32'h2);
    chk("t5 resume data", 32'(od0), 32'hA2);

    // 3-channel wrap with ch2/ch0 only, then a mid-stream reset clears the pointer.
    rst_n = 1'b0;
    step(1);
    rst_n    = 1'b1;
    in_valid = 4'b0010;
    step(1);
    in_valid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t6 out_ch", 32'(och2), 32'(exp_seq[i]));
      chk("t6 out_data", 32'(od2), 32'(8'hA0 + exp_seq[i]));
    end
    rst_n = 1'b0;
    step(1);
    chk("t6 reset valid", 32'(ov2), 32'h0);
    rst_n = 1'b1;
    step(1);
    chk("t6 ptr cleared ch", 32'(och2), 32'h0);
    chk("t6 ptr cleared valid", 32'(ov2), 32'h1);

    // Mixed enable / back-pressure / sparse request vectors, model-checked.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) begin
        logic [5:0] v;
        logic [7:0] s;
        v         = vec[i];
        s         = 8'(i + 16 * r);
        enb       = v[5];
        out_ready = v[4];
        in_valid  = v[3:0];
        in_data   = 32'hC3C2C1C0 ^ {4{s}};
        step(1);
      end
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
